// File: rtl/mult_div_ctrl.sv
// Sequential 32-bit multiply/divide unit. It takes one result bit per cycle, using shift-add
// for multiply and restoring shift-subtract for divide, and presents the result on HI/LO.
module mult_div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              Busy,
    output logic              Done,
    output logic              DivZero,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    // state | meaning
    // IDLE  | waiting for Start, operands captured on the accepting edge
    // PREP  | signs and magnitudes prepared, divide-by-zero short-cut
    // CALC  | 32 iterations, one result bit per cycle
    // FIX   | sign correction, HI/LO written on exit
    // DONE  | one-cycle Done pulse
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    localparam int CNT_W = $clog2(DATA_W);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   a_reg, b_reg, opnd;
    logic [1:0]          op_reg;
    logic                sign_a, sign_b;
    logic [2*DATA_W-1:0] acc;

    logic                is_div, is_signed, div_by_zero;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] mul_next, div_next, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign is_div      = op_reg[1];
    assign is_signed   = ~op_reg[0];
    assign div_by_zero = is_div && (b_reg == '0);

    assign mag_a = (is_signed && a_reg[DATA_W-1]) ? -a_reg : a_reg;
    assign mag_b = (is_signed && b_reg[DATA_W-1]) ? -b_reg : b_reg;

    // Multiply: the multiplier sits in the low half and shifts out while the product shifts in.
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};

    // Divide: the remainder is in the high half and the dividend/quotient shifts through the low half.
    assign div_shift = acc[2*DATA_W-1:DATA_W-1];
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_next  = div_ge ? {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1}
                              : {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};

    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    assign quo_fix  = (sign_a ^ sign_b) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign rem_fix  = sign_a ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = PREP;
            PREP:    state_nxt = div_by_zero ? DONE : CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            opnd    <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            acc     <= '0;
            DivZero <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        op_reg <= Op;
                        if (!(Op[1] && (B == '0))) DivZero <= 1'b0;
                    end
                end
                PREP: begin
                    sign_a <= is_signed & a_reg[DATA_W-1];
                    sign_b <= is_signed & b_reg[DATA_W-1];
                    cnt    <= '1;
                    if (is_div) begin
                        acc  <= {{DATA_W{1'b0}}, mag_a};
                        opnd <= mag_b;
                    end else begin
                        acc  <= {{DATA_W{1'b0}}, mag_b};
                        opnd <= mag_a;
                    end
                    if (div_by_zero) begin
                        Hi      <= a_reg;
                        Lo      <= '1;
                        DivZero <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (is_div) begin
                        Hi <= rem_fix;
                        Lo <= quo_fix;
                    end else begin
                        {Hi, Lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule
